// File: rtl/wb_trace_pkg.sv
// Shared types, default sizes and status-word layout for the writeback trace buffer.
package wb_trace_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_W   = 5;
    localparam int DISP_W     = 32;

    // Status-word layout: {count[15:0], 3'b000, overflow, 7'b0, head_rd[4:0]}
    localparam int STAT_RD_LSB  = 0;
    localparam int STAT_OVF_BIT = 12;
    localparam int STAT_CNT_LSB = 16;
    localparam int STAT_CNT_W   = 16;

    typedef struct packed {
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_DATA_W-1:0] data;
    } trace_entry_t;

    // Assemble the status word shown when display_sel is 1.
    function automatic logic [DISP_W-1:0] status_word(
        input logic [STAT_CNT_W-1:0] cnt,
        input logic                  ovf,
        input logic [DEF_RD_W-1:0]   rd
    );
        logic [DISP_W-1:0] w;
        w                              = {DISP_W{1'b0}};
        w[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
        w[STAT_OVF_BIT]                = ovf;
        w[STAT_RD_LSB +: DEF_RD_W]     = rd;
        return w;
    endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Push-button conditioning: two-flop synchronizer, rising-edge detect, and a
// registered single-cycle pulse. A button sampled high at edge N yields a
// pulse during the cycle after edge N+2, so the consumer acts on edge N+3.
module step_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;
    logic w_rise;

    assign w_rise  = r_sync2 & ~r_prev;
    assign o_pulse = r_pulse;

    // Synchronize the raw button, remember the previous level, register the edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= w_rise;
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: records register writes (rd, data) into a FIFO that
// the user steps through with a push-button; drives the hex display value.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_reg_write,
    input  logic [RD_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              capture_en,
    input  logic              clear,
    input  logic              step_btn,
    input  logic              display_sel,
    output logic [31:0]       display_value,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_entry_t     r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_pop_req;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;
    logic             w_full;
    trace_entry_t     w_new_entry;
    trace_entry_t     w_head;
    logic [31:0]      w_display;

    step_sync_edge u_step (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (step_btn),
        .o_pulse (w_pop_req)
    );

    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_push_req  = wb_reg_write & capture_en & (wb_rd != {RD_W{1'b0}});
    assign w_pop       = w_pop_req & ~w_empty;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_new_entry = '{rd: wb_rd, data: wb_data};
    assign w_head      = r_mem[r_rd_ptr];

    // Pointer, occupancy and sticky overflow update; clear outranks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage; contents are not reset, only the pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_push && !clear && !reset) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // Display mux: head data or status word, with head fields forced to 0 when empty.
    always_comb begin
        w_display = 32'd0;
        if (display_sel) begin
            if (w_empty) begin
                w_display = status_word(STAT_CNT_W'(r_count), r_overflow, {DEF_RD_W{1'b0}});
            end else begin
                w_display = status_word(STAT_CNT_W'(r_count), r_overflow, w_head.rd);
            end
        end else begin
            if (w_empty) begin
                w_display = 32'd0;
            end else begin
                w_display = 32'(w_head.data);
            end
        end
    end

    assign display_value = w_display;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a queue-based reference model predicts
// the state after each clock edge; a negedge monitor compares the DUT outputs.
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              capture_en;
    logic              clear;
    logic              step_btn;
    logic              display_sel;
    logic [31:0]       display_value;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;

    wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(32), .RD_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .capture_en    (capture_en),
        .clear         (clear),
        .step_btn      (step_btn),
        .display_sel   (display_sel),
        .display_value (display_value),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .overflow      (overflow)
    );

    typedef struct {
        int          cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic [31:0] disp;
    } exp_t;

    // Reference model state
    trace_entry_t m_q[$];
    logic         m_ovf;
    logic [3:0]   m_hist;   // button level sampled at the last four edges, [0] newest

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the spec rules for one clock edge using the inputs that were driven into it.
    task automatic model_edge();
        logic pop_req, push_req, do_pop, do_push;
        if (reset) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_hist = 4'b0000;
        end else begin
            // Button high at edge N and low at N-1 pops at edge N+3.
            pop_req  = m_hist[2] & ~m_hist[3];
            push_req = wb_reg_write & capture_en & (wb_rd != 5'd0);
            if (clear) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                do_pop  = pop_req && (m_q.size() > 0);
                do_push = push_req && ((m_q.size() < DEPTH) || do_pop);
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back('{rd: wb_rd, data: wb_data});
                if (push_req && !do_push) m_ovf = 1'b1;
            end
            m_hist = {m_hist[2:0], step_btn};
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.cnt = m_q.size();
        e.emp = (m_q.size() == 0);
        e.ful = (m_q.size() == DEPTH);
        e.ovf = m_ovf;
        if (display_sel) begin
            e.disp = {16'(m_q.size()), 3'b000, m_ovf, 7'b0000000,
                      (m_q.size() == 0) ? 5'd0 : m_q[0].rd};
        end else begin
            e.disp = (m_q.size() == 0) ? 32'd0 : m_q[0].data;
        end
        exp_q.push_back(e);
    endtask

    // One clock: model the edge, pick a display_sel for the following cycle, queue expectation.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        display_sel = 1'($urandom_range(0, 1));
        push_expect();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wb(input logic w, input logic [4:0] rd, input logic [31:0] d);
        wb_reg_write = w;
        wb_rd        = rd;
        wb_data      = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against every queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("empty", 32'(empty), 32'(e.emp));
            chk("full", 32'(full), 32'(e.ful));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk(display_sel ? "display_status" : "display_data", display_value, e.disp);
        end
    end

    initial begin
        int hold;
        vectors     = 0;
        miscompares = 0;
        m_ovf       = 1'b0;
        m_hist      = 4'b0000;
        reset       = 1'b1;
        clear       = 1'b0;
        capture_en  = 1'b1;
        step_btn    = 1'b0;
        display_sel = 1'b0;
        wb(1'b0, 5'd0, 32'd0);

        // Reset, then idle
        ticks(2);
        reset = 1'b0;
        ticks(10);

        // rd=5 recorded, rd=0 ignored
        wb(1'b1, 5'd5, 32'hDEADBEEF); tick();
        wb(1'b1, 5'd0, 32'h12345678); tick();
        wb(1'b0, 5'd0, 32'd0);        ticks(4);

        // Three entries, held button gives exactly one pop
        clear = 1'b1; tick(); clear = 1'b0;
        wb(1'b1, 5'd1, 32'h11); tick();
        wb(1'b1, 5'd2, 32'h22); tick();
        wb(1'b1, 5'd3, 32'h33); tick();
        wb(1'b0, 5'd0, 32'd0);
        step_btn = 1'b1; ticks(20);
        step_btn = 1'b0; ticks(4);

        // Fill past DEPTH, then push coinciding with a pop while full
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wb(1'b1, 5'(i % 31 + 1), $urandom); tick();
        end
        wb(1'b0, 5'd0, 32'd0);
        step_btn = 1'b1; ticks(3);
        wb(1'b1, 5'd9, 32'hCAFE0009); tick();
        wb(1'b0, 5'd0, 32'd0); step_btn = 1'b0; ticks(4);

        // Empty buffer: push and pop request on the same edge
        clear = 1'b1; tick(); clear = 1'b0; ticks(2);
        step_btn = 1'b1; ticks(3);
        wb(1'b1, 5'd7, 32'h00C0FFEE); tick();
        wb(1'b0, 5'd0, 32'd0); step_btn = 1'b0; ticks(3);
        // clear together with push
        clear = 1'b1; wb(1'b1, 5'd8, 32'h88); tick();
        clear = 1'b0; wb(1'b0, 5'd0, 32'd0); ticks(2);

        // capture disabled blocks pushes
        capture_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb(1'b1, 5'(i + 1), $urandom); tick();
        end
        capture_en = 1'b1;
        // four entries, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            wb(1'b1, 5'(i + 10), $urandom); tick();
        end
        reset = 1'b1; tick();
        reset = 1'b0; wb(1'b0, 5'd0, 32'd0); ticks(3);

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            wb(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom);
            capture_en = ($urandom_range(0, 99) < 90);
            clear      = ($urandom_range(0, 199) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            if (hold == 0) begin
                step_btn = ~step_btn;
                hold     = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            tick();
        end
        reset = 1'b0; clear = 1'b0; wb(1'b0, 5'd0, 32'd0);
        ticks(2);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Debug capture stage directly downstream of the pipelined core's writeback stage. Records every architectural register write (rd, data) into a FIFO. The board user steps through the recorded writes one at a time with a push-button. Its 32-bit display output drives the existing eight hex_decoder instances in place of the raw ALU/writeback value.

Parameters:
DEPTH, 16, number of trace entries; power of two, >= 2
DATA_W, 32, writeback data width
RD_W, 5, destination register address width
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  in  1  core clock, rising-edge
reset  in  1  synchronous, active-high reset
wb_reg_write  in  1  writeback-stage register write enable
wb_rd  in  RD_W  writeback destination register
wb_data  in  DATA_W  writeback data
capture_en  in  1  level; 0 suspends recording
clear  in  1  synchronous flush of buffer and flags
step_btn  in  1  raw, asynchronous push-button (active-high)
display_sel  in  1  0 = head data, 1 = head status word
display_value  out  32  value for hex decoders
count  out  CNT_W  current occupancy
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky; a write was dropped while full

Behaviour:
- Reset: FIFO pointers, count, overflow and synchronizer/edge flops all 0. Outputs are then display_value=0, count=0, empty=1, full=0, overflow=0. Memory contents are don't-care.
- Push qualifier: push_req = wb_reg_write & capture_en & (wb_rd != 0). Writes to x0 are never recorded.
- Step path: step_btn passes through a 2-flop synchronizer, then a rising-edge detect against a third flop. pop_req is a single-cycle pulse.
- Latency: step_btn sampled high at edge N gives pop_req during cycle N+2 and a pop at edge N+3. The new head is visible after edge N+3. A held button gives exactly one pop.
- Pop only when !empty. pop_req while empty is ignored and has no side effect.
- Push when push_req & (!full | pop). Entry {wb_rd, wb_data} is written at the tail on the clock edge. It is visible at the head after that edge if the buffer was empty.
- Simultaneous push+pop while non-empty: both occur, count unchanged. This holds even when full: the push is accepted and overflow is not set.
- Simultaneous push+pop while empty: pop ignored, push accepted, count becomes 1.
- Full with push_req and no pop: entry dropped, overflow set to 1. overflow stays set until clear or reset.
- Pointers wrap modulo DEPTH. count is computed separately, so full and empty are unambiguous.
- clear: highest priority, above push and pop in the same cycle. Pointers, count and overflow go to 0. The synchronizer is not cleared.
- reset has priority over everything.
- display_value is combinational from the head entry and registered state:
  - sel=0: head data, or 0 when empty.
  - sel=1: {count zero-extended to 16 bits, 3'b000, overflow, 7'b0, head_rd}; head_rd=0 when empty.
- capture_en=0 blocks pushes only. Stepping and clear remain functional.

Decomposition:
- Package wb_trace_pkg:
  - typedef struct packed {logic [RD_W-1:0] rd; logic [DATA_W-1:0] data;} trace_entry_t
  - default DEPTH/DATA_W/RD_W constants
  - status-word field offsets
- Sub-module step_sync_edge: 2-flop synchronizer plus rising-edge pulse, with synchronous active-high reset.
- FIFO storage, pointers and display mux stay in wb_trace_buffer.

Test Plan:
- Reset then idle -> display_value=0, count=0, empty=1, overflow=0 for 10 cycles regardless of display_sel.
- Push rd=5 data=0xDEADBEEF, then rd=0 data=0x12345678 -> count=1. sel=0 shows 0xDEADBEEF; sel=1 shows 0x00010005.
- Push 3 entries (0x11,0x22,0x33). Hold step_btn high 20 cycles -> exactly one pop, occurring 3 edges after the first sample; display goes 0x11->0x22; count=2.
- Push 17 entries with DEPTH=16 -> full=1, overflow=1, count=16, head=first entry. Then assert push and a step pop pulse in the same cycle -> count stays 16, overflow stays 1.
- Empty buffer with push and pop_req in the same cycle -> count=1, head=new entry. Then clear together with push -> count=0, overflow=0, empty=1.
- capture_en=0 with 5 valid writebacks -> count stays 0. Assert reset mid-stream with 4 entries held -> next cycle count=0, display_value=0.
